bsg_manycore_trace_arbiter: RTL and testbench

- Shares one trace output channel among num_in_p per-tile pipeline trace sources.
- Each source gets a single-entry buffer that never stalls its core. Buffers drain to one valid/ready output under round-robin arbitration.
- Records that cannot be buffered are dropped and counted.
- Sits between the per-tile vscale pipeline trace taps and the testbench trace sink / file writer.

---
 rtl/bsg_manycore_trace_pkg.sv | 28 ++
 rtl/bsg_manycore_trace_rr_arb.sv | 54 +++++
 rtl/bsg_manycore_trace_arbiter.sv | 129 ++++++++++++
 tb/tb_bsg_manycore_trace_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_trace_pkg.sv
// Shared types and helpers for the manycore pipeline trace arbiter.
// One trace record is {x, y, pc, reg_id, wb_data, flags}.
package bsg_manycore_trace_pkg;

    typedef struct packed {
        logic       imem_wait;
        logic       dmem_wait;
        logic       dmem_en;
        logic [3:0] exception_code;
    } trace_flags_t;

    typedef struct packed {
        logic [25:0]  x;
        logic [25:0]  y;
        logic [31:0]  pc;
        logic [4:0]   reg_id;
        logic [31:0]  wb_data;
        trace_flags_t flags;
    } trace_rec_t;

    localparam int trace_rec_width_lp = $bits(trace_rec_t);

    // Source-id width; a single source still needs one bit to carry an id.
    function automatic int trace_id_width(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/bsg_manycore_trace_rr_arb.sv
// Round-robin grant selection starting at rr_ptr; a held grant overrides the
// search while the output is locked by back-pressure.
module bsg_manycore_trace_rr_arb
    import bsg_manycore_trace_pkg::*;
#(
    parameter int num_in_p   = 4,
    parameter int id_width_p = trace_id_width(num_in_p)
) (
    input  logic [num_in_p-1:0]   reqs,
    input  logic [id_width_p-1:0] rr_ptr,
    input  logic                  lock,
    input  logic [id_width_p-1:0] held_grant,
    output logic [num_in_p-1:0]   grant_oh,
    output logic [id_width_p-1:0] grant_id
);

    logic [id_width_p-1:0] search_id_s;
    logic [id_width_p-1:0] idx_s;
    logic                  found_s;
    int                    idx_v;

    // First requester at or after rr_ptr, wrapping modulo num_in_p.
    always_comb begin
        search_id_s = '0;
        found_s     = 1'b0;
        idx_v       = 0;
        idx_s       = '0;
        for (int k = 0; k < num_in_p; k++) begin
            idx_v = int'(rr_ptr) + k;
            idx_v = (idx_v >= num_in_p) ? (idx_v - num_in_p) : idx_v;
            idx_s = id_width_p'(idx_v);
            if (!found_s && reqs[idx_s]) begin
                found_s     = 1'b1;
                search_id_s = idx_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Locked grant wins; one-hot is qualified by any request being present.
    always_comb begin
        grant_oh = '0;
        if (lock) begin
            grant_id = held_grant;
        end else begin
            grant_id = search_id_s;
        end
        for (int i = 0; i < num_in_p; i++) begin
            grant_oh[i] = (|reqs) & (grant_id == id_width_p'(i));
        end
    end

endmodule

// File: rtl/bsg_manycore_trace_arbiter.sv
// Per-tile single-entry trace buffers drained round-robin to one valid/ready
// channel; records arriving at a busy buffer are dropped and counted.
module bsg_manycore_trace_arbiter
    import bsg_manycore_trace_pkg::*;
#(
    parameter int num_in_p    = 4,
    parameter int rec_width_p = trace_rec_width_lp,
    parameter int cnt_width_p = 16,
    parameter int id_width_p  = trace_id_width(num_in_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_in_p-1:0]             v_i,
    input  logic [num_in_p*rec_width_p-1:0] data_i,
    output logic                            v_o,
    output logic [rec_width_p-1:0]          data_o,
    output logic [id_width_p-1:0]           src_id_o,
    input  logic                            ready_i,
    input  logic                            clear_i,
    output logic [cnt_width_p-1:0]          drop_count_o,
    output logic [num_in_p-1:0]             overflow_o
);

    localparam int sum_width_lp = cnt_width_p + 1;

    logic [num_in_p-1:0]    full_r;
    logic [rec_width_p-1:0] data_r [num_in_p];
    logic [id_width_p-1:0]  rr_ptr_r, grant_r, grant_s, rr_next_s;
    logic                   lock_r, accept_s;
    logic [num_in_p-1:0]    grant_oh_s, deq_s, load_s, drop_s;
    logic [cnt_width_p-1:0] drop_count_r, cnt_next_s;
    logic [num_in_p-1:0]    overflow_r;
    logic [sum_width_lp-1:0] pop_s, sum_s;

    bsg_manycore_trace_rr_arb #(
        .num_in_p  (num_in_p),
        .id_width_p(id_width_p)
    ) rr_arb (
        .reqs      (full_r),
        .rr_ptr    (rr_ptr_r),
        .lock      (lock_r),
        .held_grant(grant_r),
        .grant_oh  (grant_oh_s),
        .grant_id  (grant_s)
    );

    // Output mux and per-buffer load/dequeue/drop decisions.
    always_comb begin
        v_o       = |full_r;
        accept_s  = v_o & ready_i;
        data_o    = data_r[grant_s];
        src_id_o  = grant_s;
        deq_s     = grant_oh_s & {num_in_p{accept_s}};
        load_s    = v_i & (~full_r | deq_s);
        drop_s    = v_i & full_r & ~deq_s;
        rr_next_s = (grant_s == id_width_p'(num_in_p - 1)) ? '0 : (grant_s + id_width_p'(1));
    end

    // Saturating drop counter: add at one extra bit, clamp on carry-out.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < num_in_p; i++) begin
            pop_s = pop_s + sum_width_lp'(drop_s[i]);
        end
        sum_s = {1'b0, drop_count_r} + pop_s;
        if (sum_s[cnt_width_p]) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = sum_s[cnt_width_p-1:0];
        end
    end

    // Buffer storage; a same-cycle dequeue and load replaces the record.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_r <= '0;
            for (int i = 0; i < num_in_p; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_in_p; i++) begin
                if (load_s[i]) begin
                    full_r[i] <= 1'b1;
                    data_r[i] <= data_i[i*rec_width_p +: rec_width_p];
                end else if (deq_s[i]) begin
                    full_r[i] <= 1'b0;
                end else begin
                    full_r[i] <= full_r[i];
                end
            end
        end
    end

    // Arbitration state: pointer advances past the accepted source; a stalled
    // offer locks the grant so data_o stays stable until accepted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_r <= '0;
            grant_r  <= '0;
            lock_r   <= 1'b0;
        end else if (accept_s) begin
            rr_ptr_r <= rr_next_s;
            lock_r   <= 1'b0;
        end else if (v_o) begin
            grant_r  <= grant_s;
            lock_r   <= 1'b1;
        end else begin
            lock_r   <= 1'b0;
        end
    end

    // Drop statistics; clear takes priority over same-cycle drops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_count_r <= '0;
            overflow_r   <= '0;
        end else if (clear_i) begin
            drop_count_r <= '0;
            overflow_r   <= '0;
        end else begin
            drop_count_r <= cnt_next_s;
            overflow_r   <= overflow_r | drop_s;
        end
    end

    assign drop_count_o = drop_count_r;
    assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_bsg_manycore_trace_arbiter.sv
// Scoreboard bench for the trace arbiter: stimulus pushes the expected
// (source, record) sequence, a negedge monitor checks every accepted output.
module tb_bsg_manycore_trace_arbiter;

    localparam int N  = 4;
    localparam int RW = 128;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [N-1:0]    v_i;
    logic [N*RW-1:0] data_i;
    logic            v_o;
    logic [RW-1:0]   data_o;
    logic [IW-1:0]   src_id_o;
    logic            ready_i;
    logic            clear_i;
    logic [CW-1:0]   drop_count_o;
    logic [N-1:0]    overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [IW-1:0] src;
        logic [RW-1:0] rec;
    } exp_t;
    exp_t exp_q[$];

    bsg_manycore_trace_arbiter #(
        .num_in_p   (N),
        .rec_width_p(RW),
        .cnt_width_p(CW)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .src_id_o    (src_id_o),
        .ready_i     (ready_i),
        .clear_i     (clear_i),
        .drop_count_o(drop_count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int s, input int tag);
        return {32'hABCD_0000 | 32'(tag), 32'(s), 64'h0123_4567_89AB_CDEF};
    endfunction

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int s, input logic [RW-1:0] r);
        exp_t e;
        e.src = IW'(s);
        e.rec = r;
        exp_q.push_back(e);
    endtask

    task automatic set_rec(input int s, input logic [RW-1:0] r);
        data_i[s*RW +: RW] = r;
    endtask

    // Monitor: every accepted transfer must match the head of the queue.
    always @(negedge clk_i) begin
        if (reset_n_i && v_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", RW'(src_id_o), RW'(9));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_src", RW'(src_id_o), RW'(e.src));
                check("sb_data", data_o, e.rec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] r1;
        reset_n_i = 1'b0;
        v_i = '0;
        data_i = '0;
        ready_i = 1'b1;
        clear_i = 1'b0;
        #23;
        reset_n_i = 1'b1;
        check("rst_v_o", RW'(v_o), RW'(0));
        check("rst_drop_count", RW'(drop_count_o), RW'(0));
        check("rst_overflow", RW'(overflow_o), RW'(0));

        // Two all-source bursts: pointer wraps to 0, order 0,1,2,3 both times.
        for (int b = 0; b < 2; b++) begin
            cycle();
            v_i = 4'b1111;
            for (int s = 0; s < N; s++) begin
                set_rec(s, mk(s, 16 + b * 4 + s));
                push(s, mk(s, 16 + b * 4 + s));
            end
            cycle();
            v_i = '0;
            repeat (4) cycle();
            check("burst_drained", RW'(v_o), RW'(0));
        end

        // Back-pressure with sources 1 and 3 full; pulse source 1 mid-stall.
        ready_i = 1'b0;
        v_i = 4'b1010;
        r1 = mk(1, 32'h40);
        set_rec(1, r1);
        set_rec(3, mk(3, 32'h41));
        push(1, r1);
        push(3, mk(3, 32'h41));
        cycle();
        v_i = '0;
        for (int k = 0; k < 5; k++) begin
            check("stall_src_id", RW'(src_id_o), RW'(1));
            check("stall_data", data_o, r1);
            v_i = (k == 1) ? 4'b0010 : 4'b0000;
            set_rec(1, mk(1, 32'h99));
            cycle();
        end
        v_i = '0;
        check("stall_drop_count", RW'(drop_count_o), RW'(1));
        check("stall_overflow", RW'(overflow_o), RW'(4'b0010));
        ready_i = 1'b1;
        repeat (2) cycle();
        check("stall_drained", RW'(v_o), RW'(0));
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        check("clear_drop_count", RW'(drop_count_o), RW'(0));
        check("clear_overflow", RW'(overflow_o), RW'(0));

        // Single source 2, minimum latency.
        v_i = 4'b0100;
        set_rec(2, mk(2, 32'hABCD));
        push(2, mk(2, 32'hABCD));
        cycle();
        v_i = '0;
        check("single_v_o_t1", RW'(v_o), RW'(1));
        cycle();
        check("single_v_o_t2", RW'(v_o), RW'(0));
        check("single_drop_count", RW'(drop_count_o), RW'(0));

        // Same-cycle dequeue and reload on source 0.
        v_i = 4'b0001;
        set_rec(0, mk(0, 32'hA0));
        push(0, mk(0, 32'hA0));
        push(0, mk(0, 32'hB0));
        cycle();
        set_rec(0, mk(0, 32'hB0));
        cycle();
        v_i = '0;
        check("replace_v_o", RW'(v_o), RW'(1));
        cycle();
        check("replace_drained", RW'(v_o), RW'(0));
        check("replace_no_drop", RW'(drop_count_o), RW'(0));

        // Saturation: one load then 20 drops on source 0 while stalled.
        ready_i = 1'b0;
        for (int i = 0; i < 21; i++) begin
            v_i = 4'b0001;
            set_rec(0, (i == 0) ? mk(0, 32'h50) : mk(0, 32'h77));
            cycle();
        end
        push(0, mk(0, 32'h50));
        v_i = '0;
        check("sat_drop_count", RW'(drop_count_o), RW'(15));
        check("sat_overflow", RW'(overflow_o), RW'(4'b0001));
        v_i = 4'b0010;
        set_rec(1, mk(1, 32'h51));
        push(1, mk(1, 32'h51));
        cycle();
        v_i = 4'b0011;
        set_rec(0, mk(0, 32'h78));
        set_rec(1, mk(1, 32'h78));
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        v_i = '0;
        check("clear_wins_count", RW'(drop_count_o), RW'(0));
        check("clear_wins_overflow", RW'(overflow_o), RW'(0));
        ready_i = 1'b1;
        repeat (2) cycle();
        check("sat_drained", RW'(v_o), RW'(0));

        // Asynchronous reset while an offer is stalled.
        ready_i = 1'b0;
        v_i = 4'b0100;
        set_rec(2, mk(2, 32'h60));
        cycle();
        v_i = '0;
        check("pre_reset_v_o", RW'(v_o), RW'(1));
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_reset_v_o", RW'(v_o), RW'(0));
        #3;
        reset_n_i = 1'b1;
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post_reset_idle", RW'(v_o), RW'(0));
        end
        v_i = 4'b1000;
        set_rec(3, mk(3, 32'h61));
        push(3, mk(3, 32'h61));
        cycle();
        v_i = '0;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            cycle();
        end
        check("queue_empty", RW'(exp_q.size()), RW'(0));
        check("final_idle", RW'(v_o), RW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
